cordic_vectoring_controller: RTL and testbench

Sequencing FSM for the CORDIC vectoring-mode datapath. On a `start` pulse it loads the operands, clears the phase register, and captures the initial sign of y. It then issues `ITERATIONS` micro-rotation cycles, driving the datapath's register loads, mux selects, ALU operations, shift amount and atan-ROM address. It reports completion with a one-cycle `done` pulse, at which point `z_out` is valid.

---
 rtl/cordic_vectoring_controller.sv | 124 ++++++++++++
 tb/tb_cordic_vectoring_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring_controller.sv
// rtl/cordic_vectoring_controller.sv - sequencing FSM for the CORDIC vectoring-mode datapath
// Loads operands, captures the initial sign of y, then issues ITERATIONS micro-rotations.
module cordic_vectoring_controller #(
  parameter int ITERATIONS     = 16,
  parameter int ADDRESS_LENGTH = 4,
  parameter int SHIFT_LENGTH   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      sign_y,
  output logic                      load_x,
  output logic                      load_y,
  output logic                      load_z,
  output logic                      load_d,
  output logic                      load_d0,
  output logic                      clear_z,
  output logic [1:0]                sel_x,
  output logic [1:0]                sel_y,
  output logic [1:0]                sel_z,
  output logic                      alu_op_x,
  output logic                      alu_op_y,
  output logic                      alu_op_z,
  output logic [ADDRESS_LENGTH-1:0] rom_address,
  output logic [SHIFT_LENGTH-1:0]   shift_amount,
  output logic                      busy,
  output logic                      done
);

  localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(ITERATIONS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SIGN,
    S_ITER,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        iter_d  = '0;
        state_d = S_SIGN;
      end
      S_SIGN: state_d = S_ITER;
      S_ITER: begin
        // The counter parks on the last index so the final ROM address stays in range.
        if (iter_q == LAST_ITER) state_d = S_DONE;
        else                     iter_d  = iter_q + CW'(1);
      end
      S_DONE: state_d = start ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_x       = 1'b0;
    load_y       = 1'b0;
    load_z       = 1'b0;
    load_d       = 1'b0;
    load_d0      = 1'b0;
    clear_z      = 1'b0;
    sel_x        = 2'b00;
    sel_y        = 2'b00;
    sel_z        = 2'b00;
    alu_op_x     = 1'b0;
    alu_op_y     = 1'b0;
    alu_op_z     = 1'b0;
    rom_address  = '0;
    shift_amount = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_LOAD: begin
        load_x  = 1'b1;
        load_y  = 1'b1;
        clear_z = 1'b1;
        busy    = 1'b1;
      end
      S_SIGN: begin
        load_d0 = 1'b1;
        load_d  = 1'b1;
        busy    = 1'b1;
      end
      S_ITER: begin
        load_x       = 1'b1;
        load_y       = 1'b1;
        load_z       = 1'b1;
        load_d       = 1'b1;
        sel_x        = 2'b10;
        sel_y        = 2'b10;
        sel_z        = 2'b01;
        // Rotation direction follows the live sign of y within the same cycle.
        alu_op_x     = sign_y;
        alu_op_y     = ~sign_y;
        alu_op_z     = sign_y;
        rom_address  = ADDRESS_LENGTH'(iter_q);
        shift_amount = SHIFT_LENGTH'(iter_q);
        busy         = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cordic_vectoring_controller.sv
// tb/tb_cordic_vectoring_controller.sv - self-checking bench for cordic_vectoring_controller
// A behavioural datapath closes the sign_y loop; outputs are compared every cycle.
module tb_cordic_vectoring_controller;

  localparam int  N     = 16;
  localparam real PI    = 3.14159265358979;
  localparam real ZSCL  = 32768.0 / PI;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sign_y;
  logic       load_x, load_y, load_z, load_d, load_d0, clear_z;
  logic [1:0] sel_x, sel_y, sel_z;
  logic       alu_op_x, alu_op_y, alu_op_z;
  logic [3:0] rom_address;
  logic [4:0] shift_amount;
  logic       busy, done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cordic_vectoring_controller #(
    .ITERATIONS(N), .ADDRESS_LENGTH(4), .SHIFT_LENGTH(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sign_y(sign_y),
    .load_x(load_x), .load_y(load_y), .load_z(load_z), .load_d(load_d),
    .load_d0(load_d0), .clear_z(clear_z),
    .sel_x(sel_x), .sel_y(sel_y), .sel_z(sel_z),
    .alu_op_x(alu_op_x), .alu_op_y(alu_op_y), .alu_op_z(alu_op_z),
    .rom_address(rom_address), .shift_amount(shift_amount),
    .busy(busy), .done(done)
  );

  // Datapath: 24-bit x/y with 6 guard bits, z kept in real radians with an exact atan table.
  logic [15:0]        x_in = '0, y_in = '0;
  logic signed [23:0] xr = '0, yr = '0, x_ext, y_ext;
  real                zr = 0.0;
  real                atan_tab [16];
  logic               d0r = 1'b0, dr = 1'b0;

  assign x_ext  = {{8{x_in[15]}}, x_in} <<< 6;
  assign y_ext  = {{8{y_in[15]}}, y_in} <<< 6;
  assign sign_y = yr[23];

  always @(posedge clk) begin
    if (load_x) xr <= (sel_x == 2'b00) ? x_ext :
                      (alu_op_x ? xr - (yr >>> shift_amount) : xr + (yr >>> shift_amount));
    if (load_y) yr <= (sel_y == 2'b00) ? y_ext :
                      (alu_op_y ? yr - (xr >>> shift_amount) : yr + (xr >>> shift_amount));
    if (clear_z)     zr <= 0.0;
    else if (load_z) zr <= alu_op_z ? zr - atan_tab[rom_address] : zr + atan_tab[rom_address];
    if (load_d0) d0r <= sign_y;
    if (load_d)  dr  <= sign_y;
  end

  // Reference: cycles elapsed since the accepted start (-1 = idle; 0 LOAD, 1 SIGN, 2..N+1 ITER, N+2 DONE).
  int ref_k = -1;
  always @(posedge clk or posedge rst) begin
    if (rst)                          ref_k <= -1;
    else if (ref_k == -1 || ref_k == N + 2) ref_k <= start ? 0 : -1;
    else                              ref_k <= ref_k + 1;
  end

  function automatic logic [25:0] out_vec();
    return {load_x, load_y, load_z, load_d, load_d0, clear_z, sel_x, sel_y, sel_z,
            alu_op_x, alu_op_y, alu_op_z, rom_address, shift_amount, busy, done};
  endfunction

  function automatic logic [25:0] expect_vec(int k, logic s);
    logic lx, ly, lz, ld, ld0, cz, ax, ay, az, b, dn;
    logic [1:0] sx, sy, sz;
    logic [3:0] ra;
    logic [4:0] sa;
    {lx, ly, lz, ld, ld0, cz, ax, ay, az, b, dn} = '0;
    sx = '0; sy = '0; sz = '0; ra = '0; sa = '0;
    if (k == 0) begin
      lx = 1; ly = 1; cz = 1; b = 1;
    end else if (k == 1) begin
      ld = 1; ld0 = 1; b = 1;
    end else if (k >= 2 && k <= N + 1) begin
      lx = 1; ly = 1; lz = 1; ld = 1; b = 1;
      sx = 2'b10; sy = 2'b10; sz = 2'b01;
      ax = s; ay = ~s; az = s;
      ra = 4'(k - 2); sa = 5'(k - 2);
    end else if (k == N + 2) begin
      dn = 1;
    end
    return {lx, ly, lz, ld, ld0, cz, sx, sy, sz, ax, ay, az, ra, sa, b, dn};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_near(input string name, input int act, input int req, input int tol);
    checks++;
    if (act > req + tol || act < req - tol) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d+-%0d", name, act, req, tol);
    end
  endtask

  task automatic check_outputs();
    logic [25:0] e;
    e = expect_vec(ref_k, sign_y);
    checks++;
    if (out_vec() !== e) begin
      failures++;
      $display("FAIL cycle_outputs k=%0d actual=%h required=%h", ref_k, out_vec(), e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  function automatic int z_out();
    real v;
    v = zr * ZSCL;
    return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
  endfunction

  // One computation; p1/p2 are cycle indices (relative to LOAD) where start is pulsed again.
  task automatic run_and_check(input string name, input logic [15:0] xi, input logic [15:0] yi,
                               input int exp_z, input logic exp_d0, input int p1, input int p2);
    int busy_cnt, done_at, steps, rom_bad, extra;
    x_in = xi; y_in = yi;
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 0; done_at = -1; steps = 0; rom_bad = 0; extra = 0;
    for (int c = 1; c <= N + 10 && done_at < 0; c++) begin
      if (busy) busy_cnt++;
      if (load_z) begin
        if (rom_address != 4'(steps) || shift_amount != 5'(steps)) rom_bad++;
        steps++;
      end
      start = (c - 1 == p1) || (c - 1 == p2);
      tick();
      start = 1'b0;
      if (done) done_at = c;
    end
    chk({name, "_busy_len"}, busy_cnt, N + 2);
    chk({name, "_done_latency"}, done_at, N + 2);
    chk({name, "_rom_steps"}, steps, N);
    chk({name, "_rom_seq_err"}, rom_bad, 0);
    chk({name, "_d0"}, int'(d0r), int'(exp_d0));
    chk_near({name, "_z_out"}, z_out(), exp_z, 2);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done || busy) extra++;
    end
    chk({name, "_idle_after"}, extra, 0);
  endtask

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    int          exp_z;
    logic        exp_d0;
    int          p1;
    int          p2;
  } vec_t;

  vec_t tab [6];

  initial begin
    int   ndone, last, found;
    logic [15:0] rx, ry;
    for (int i = 0; i < 16; i++) atan_tab[i] = $atan(1.0 / real'(1 << i));

    tab[0] = '{16'h4000, 16'h4000,  8192, 1'b0, -1, -1};
    tab[1] = '{16'h4000, 16'hC000, -8192, 1'b1, -1, -1};
    tab[2] = '{16'h4000, 16'h4000,  8192, 1'b0,  1,  9};
    tab[3] = '{16'h4000, 16'h0000,     0, 1'b0, -1, -1};
    tab[4] = '{16'h4000, 16'h2000,  4836, 1'b0, -1, -1};
    tab[5] = '{16'h2000, 16'h4000, 11548, 1'b0, -1, -1};

    // Reset between clock edges must clear outputs with no edge.
    rst = 1'b0; start = 1'b0;
    #1 rst = 1'b1;
    #1 chk("reset_outputs", int'(out_vec()), 0);
    check_outputs();
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("reset_stays_idle", int'(busy), 0);

    for (int i = 0; i < 6; i++)
      run_and_check($sformatf("vec%0d", i), tab[i].x, tab[i].y, tab[i].exp_z,
                    tab[i].exp_d0, tab[i].p1, tab[i].p2);

    for (int i = 0; i < 6; i++) begin
      real a;
      rx = 16'($urandom_range(16'h0800, 16'h7000));
      ry = 16'($urandom_range(0, 16'hE000) - 16'h7000);
      a  = $atan2(real'($signed(ry)), real'($signed(rx))) * ZSCL;
      run_and_check($sformatf("rnd%0d", i), rx, ry, $rtoi(a >= 0.0 ? a + 0.5 : a - 0.5),
                    ry[15], $urandom_range(1, N + 1), $urandom_range(1, N + 1));
    end

    // Reset in ITER cycle 5, then a clean rerun.
    x_in = 16'h4000; y_in = 16'hC000;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int c = 0; c < N + 4 && found == 0; c++) begin
      if (load_z && rom_address == 4'd5) found = 1;
      else tick();
    end
    chk("mid_rst_reached_iter5", found, 1);
    #2 rst = 1'b1;
    #1 chk("mid_rst_outputs", int'(out_vec()), 0);
    check_outputs();
    #2 rst = 1'b0;
    tick();
    chk("mid_rst_idle", int'(busy), 0);
    run_and_check("after_rst", 16'h4000, 16'h4000, 8192, 1'b0, -1, -1);

    // Start held high: done must recur every N+3 cycles.
    x_in = 16'h4000; y_in = 16'h4000;
    start = 1'b1;
    tick();
    ndone = 0; last = 0;
    for (int c = 1; c <= 3 * (N + 3); c++) begin
      tick();
      if (done) begin
        chk("b2b_done_at", c, (ndone == 0) ? N + 2 : last + N + 3);
        chk_near("b2b_z_out", z_out(), 8192, 2);
        last = c;
        ndone++;
      end
    end
    chk("b2b_done_count", ndone, 3);
    start = 1'b0;
    for (int c = 0; c < N + 4; c++) tick();
    chk("b2b_drained", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
